// File: rtl/rom_fetch_arbiter_if.sv
// One requester port of the ROM fetch arbiter: request channel plus a
// fixed-latency response strobe with no backpressure.
interface rom_fetch_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  valid,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Two-port arbiter in front of a combinational logo ROM: port 0 has fixed
// priority, port 1 is force-granted after STARVE_LIMIT stalled cycles.
module rom_fetch_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_q,
  rom_fetch_arbiter_if.slave    p0,
  rom_fetch_arbiter_if.slave    p1
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_P0   = 2'd1,
    TAG_P1   = 2'd2
  } tag_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic              force_s;
  logic              p0_ready_s;
  logic              p1_ready_s;
  logic [7:0]        wait_cnt_r;
  logic [7:0]        wait_cnt_nxt_s;
  tag_e              tag_r;
  tag_e              tag_nxt_s;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [ADDR_W-1:0] rom_addr_nxt_s;
  logic              p0_rvalid_r;
  logic              p1_rvalid_r;
  logic [DATA_W-1:0] p0_rdata_r;
  logic [DATA_W-1:0] p1_rdata_r;

  // Grant: at most one ready per cycle; force only overrides port 0 when port 1 is waiting.
  always_comb begin
    force_s    = (wait_cnt_r == LIMIT);
    p1_ready_s = p1.valid && (!p0.valid || force_s);
    p0_ready_s = p0.valid && !(p1.valid && force_s);
  end

  // Stage-1 next state: accepted address and its owner tag; address holds when idle.
  always_comb begin
    rom_addr_nxt_s = rom_addr_r;
    tag_nxt_s      = TAG_NONE;
    if (p1_ready_s) begin
      rom_addr_nxt_s = p1.addr;
      tag_nxt_s      = TAG_P1;
    end else if (p0_ready_s) begin
      rom_addr_nxt_s = p0.addr;
      tag_nxt_s      = TAG_P0;
    end else begin
      rom_addr_nxt_s = rom_addr_r;
      tag_nxt_s      = TAG_NONE;
    end
  end

  // Starvation counter: counts stalled port-1 cycles, saturating at the limit.
  always_comb begin
    wait_cnt_nxt_s = 8'd0;
    if (p1.valid && !p1_ready_s) begin
      if (wait_cnt_r >= LIMIT) begin
        wait_cnt_nxt_s = LIMIT;
      end else begin
        wait_cnt_nxt_s = wait_cnt_r + 8'd1;
      end
    end else begin
      wait_cnt_nxt_s = 8'd0;
    end
  end

  // Stage-1 registers: ROM address, owner tag and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_r <= '0;
      tag_r      <= TAG_NONE;
      wait_cnt_r <= 8'd0;
    end else begin
      rom_addr_r <= rom_addr_nxt_s;
      tag_r      <= tag_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Stage-2 registers: ROM data lands only in the owning port's response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      p0_rdata_r  <= '0;
      p1_rdata_r  <= '0;
    end else begin
      p0_rvalid_r <= (tag_r == TAG_P0);
      p1_rvalid_r <= (tag_r == TAG_P1);
      case (tag_r)
        TAG_P0:  p0_rdata_r <= rom_q;
        TAG_P1:  p1_rdata_r <= rom_q;
        default: begin
          p0_rdata_r <= p0_rdata_r;
          p1_rdata_r <= p1_rdata_r;
        end
      endcase
    end
  end

  assign rom_addr  = rom_addr_r;
  assign p0.ready  = p0_ready_s;
  assign p1.ready  = p1_ready_s;
  assign p0.rvalid = p0_rvalid_r;
  assign p1.rvalid = p1_rvalid_r;
  assign p0.rdata  = p0_rdata_r;
  assign p1.rdata  = p1_rdata_r;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter: per-cycle vector table plus
// hand-written stream, starvation and reset sequences.
module tb_rom_fetch_arbiter;

  logic        clk;
  logic        rst_n;
  logic [11:0] rom_addr;
  logic [7:0]  rom_q;
  int          pass_cnt;
  int          total_cnt;

  rom_fetch_arbiter_if #(.ADDR_W(12), .DATA_W(8)) p0_if ();
  rom_fetch_arbiter_if #(.ADDR_W(12), .DATA_W(8)) p1_if ();

  rom_fetch_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .p0       (p0_if),
    .p1       (p1_if)
  );

  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    return a[7:0] ^ {a[3:0], a[11:8]} ^ 8'h3C;
  endfunction

  // src < 0 means the register still holds its reset value
  function automatic logic [7:0] exp_data(input int src);
    if (src < 0) return 8'h00;
    return rom_fn(12'(src));
  endfunction

  assign rom_q = rom_fn(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic v0, input logic [11:0] a0, input logic v1, input logic [11:0] a1);
    p0_if.valid = v0;
    p0_if.addr  = a0;
    p1_if.valid = v1;
    p1_if.addr  = a1;
  endtask

  typedef struct {
    logic        p0_v;
    logic [11:0] p0_a;
    logic        p1_v;
    logic [11:0] p1_a;
    logic        e_rdy0;
    logic        e_rdy1;
    logic [11:0] e_rom_addr;
    logic        e_rv0;
    int          e_src0;
    logic        e_rv1;
    int          e_src1;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic p0v, input logic [11:0] p0a, input logic p1v,
                              input logic [11:0] p1a, input logic r0, input logic r1,
                              input logic [11:0] ra, input logic rv0, input int s0,
                              input logic rv1, input int s1);
    vec_t v;
    v.p0_v = p0v; v.p0_a = p0a; v.p1_v = p1v; v.p1_a = p1a;
    v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_rom_addr = ra;
    v.e_rv0 = rv0; v.e_src0 = s0; v.e_rv1 = rv1; v.e_src1 = s1;
    return v;
  endfunction

  initial begin
    int p0_next;
    int p1_next;
    int p1_acc;
    logic exp_p1;

    pass_cnt  = 0;
    total_cnt = 0;

    // registered outputs are sampled before the row's inputs are applied
    //            p0v  p0a     p1v  p1a     rdy0 rdy1 rom_addr rv0 src0    rv1 src1
    vecs[0]  = mk(1'b1, 12'h123, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b0, -1,    1'b0, -1);
    vecs[1]  = mk(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h123, 1'b0, -1,    1'b0, -1);
    vecs[2]  = mk(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h123, 1'b1, 'h123, 1'b0, -1);
    vecs[3]  = mk(1'b0, 12'h000, 1'b1, 12'hFFF, 1'b0, 1'b1, 12'h123, 1'b0, 'h123, 1'b0, -1);
    vecs[4]  = mk(1'b1, 12'h010, 1'b0, 12'h000, 1'b1, 1'b0, 12'hFFF, 1'b0, 'h123, 1'b0, -1);
    vecs[5]  = mk(1'b0, 12'h000, 1'b1, 12'h020, 1'b0, 1'b1, 12'h010, 1'b0, 'h123, 1'b1, 'hFFF);
    vecs[6]  = mk(1'b1, 12'h030, 1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 1'b1, 'h010, 1'b0, 'hFFF);
    vecs[7]  = mk(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h030, 1'b0, 'h010, 1'b1, 'h020);
    vecs[8]  = mk(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h030, 1'b1, 'h030, 1'b0, 'h020);
    vecs[9]  = mk(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h030, 1'b0, 'h030, 1'b0, 'h020);
    vecs[10] = mk(1'b1, 12'h040, 1'b1, 12'h050, 1'b1, 1'b0, 12'h030, 1'b0, 'h030, 1'b0, 'h020);
    vecs[11] = mk(1'b0, 12'h000, 1'b1, 12'h050, 1'b0, 1'b1, 12'h040, 1'b0, 'h030, 1'b0, 'h020);
    vecs[12] = mk(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h050, 1'b1, 'h040, 1'b0, 'h020);
    vecs[13] = mk(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h050, 1'b0, 'h040, 1'b1, 'h050);
    vecs[14] = mk(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h050, 1'b0, 'h040, 1'b0, 'h050);

    // ---- reset state ----
    rst_n = 1'b0;
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    #12;
    chk("reset rom_addr", 32'(rom_addr), 32'h0);
    chk("reset p0_rvalid", 32'(p0_if.rvalid), 32'h0);
    chk("reset p1_rvalid", 32'(p1_if.rvalid), 32'h0);
    chk("reset p0_rdata", 32'(p0_if.rdata), 32'h0);
    chk("reset p1_rdata", 32'(p1_if.rdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table: single read, idle p0, interleave, simultaneous request ----
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].e_rom_addr));
      chk($sformatf("v%0d p0_rvalid", i), 32'(p0_if.rvalid), 32'(vecs[i].e_rv0));
      chk($sformatf("v%0d p1_rvalid", i), 32'(p1_if.rvalid), 32'(vecs[i].e_rv1));
      chk($sformatf("v%0d p0_rdata", i), 32'(p0_if.rdata), 32'(exp_data(vecs[i].e_src0)));
      chk($sformatf("v%0d p1_rdata", i), 32'(p1_if.rdata), 32'(exp_data(vecs[i].e_src1)));
      drive(vecs[i].p0_v, vecs[i].p0_a, vecs[i].p1_v, vecs[i].p1_a);
      #1;
      chk($sformatf("v%0d p0_ready", i), 32'(p0_if.ready), 32'(vecs[i].e_rdy0));
      chk($sformatf("v%0d p1_ready", i), 32'(p1_if.ready), 32'(vecs[i].e_rdy1));
    end

    // ---- pipelined stream 0x000..0x00F on port 0 ----
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stream%0d p0_rvalid", i), 32'(p0_if.rvalid), 32'(i >= 2 && i < 18));
      chk($sformatf("stream%0d p1_rvalid", i), 32'(p1_if.rvalid), 32'h0);
      if (i >= 2 && i < 18)
        chk($sformatf("stream%0d p0_rdata", i), 32'(p0_if.rdata), 32'(rom_fn(12'(i - 2))));
      drive(i < 16, 12'(i), 1'b0, 12'h000);
      #1;
      chk($sformatf("stream%0d p0_ready", i), 32'(p0_if.ready), 32'(i < 16));
    end

    // ---- starvation guard: both ports request every cycle ----
    p0_next = 'h100;
    p1_next = 'h200;
    p1_acc  = 0;
    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 12'(p0_next), 1'b1, 12'(p1_next));
      #1;
      exp_p1 = ((i % 9) == 8);
      chk($sformatf("prio%0d p1_ready", i), 32'(p1_if.ready), 32'(exp_p1));
      chk($sformatf("prio%0d p0_ready", i), 32'(p0_if.ready), 32'(!exp_p1));
      if (p1_if.ready) begin
        p1_acc++;
        p1_next++;
      end
      if (p0_if.ready) p0_next++;
    end
    chk("prio p1 accept count", 32'(p1_acc), 32'd3);
    @(posedge clk); #1;
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    repeat (3) @(posedge clk);

    // ---- reset with two reads in flight ----
    #1;
    drive(1'b1, 12'h300, 1'b0, 12'h000);
    @(posedge clk); #1;
    drive(1'b1, 12'h301, 1'b0, 12'h000);
    @(posedge clk); #2;
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    rst_n = 1'b0;
    #1;
    chk("midrst rom_addr", 32'(rom_addr), 32'h0);
    chk("midrst p0_rvalid", 32'(p0_if.rvalid), 32'h0);
    chk("midrst p1_rvalid", 32'(p1_if.rvalid), 32'h0);
    chk("midrst p0_rdata", 32'(p0_if.rdata), 32'h0);
    chk("midrst p1_rdata", 32'(p1_if.rdata), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 12'h305, 1'b0, 12'h000);
    #1;
    chk("postrst p0_ready", 32'(p0_if.ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 12'h000, 1'b0, 12'h000);
      chk($sformatf("postrst%0d p0_rvalid", k), 32'(p0_if.rvalid), 32'(k == 1));
      chk($sformatf("postrst%0d p1_rvalid", k), 32'(p1_if.rvalid), 32'h0);
      if (k == 1) chk("postrst p0_rdata", 32'(p0_if.rdata), 32'(rom_fn(12'h305)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
